sync_fifo_param: RTL

- Parametrised single-clock FIFO. It is the next-generation replacement for the team's fixed 8-bit x 64 buffer.
- Adds configurable width and depth, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, pass-through read+write at full, and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer datapaths in the same clock domain.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_mem_2p.sv | 31 +++
 rtl/sync_fifo_param.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_pkg: sizing helpers and default thresholds shared by FIFO variants.
// Revision: 1.0
// ------------------------------------------------------------------
package fifo_pkg;

    localparam int AF_MARGIN = 4;
    localparam int AE_MARGIN = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Occupancy needs one bit more than the pointer so that DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_mem_2p: DATA_W x DEPTH storage, synchronous write, asynchronous read, no reset.
// Revision: 1.0
// ------------------------------------------------------------------
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [clog2(DEPTH)-1:0]   raddr_i,
    output logic [DATA_W-1:0]         rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_fifo_param: parametrised single-clock FIFO with thresholds, sticky errors and optional FWFT.
// Revision: 1.0
// ------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = DEPTH - AF_MARGIN,
    parameter int AE_THRESH = AE_MARGIN,
    parameter bit FWFT      = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       clr_err,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

    if (!is_pow2(DEPTH) || (DEPTH < 4)) begin : g_chk_depth
        $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_chk_af
        $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_chk_ae
        $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] mem_rdata;

    // A write at full slips in only when a read frees the slot in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A fresh error in the clearing cycle takes priority over the clear.
        if (wr_en && !wr_acc) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end
        if (rd_en && !rd_acc) begin
            udf_d = 1'b1;
        end else if (clr_err) begin
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign count        = count_q;
    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    if (FWFT) begin : g_fwft
        // Head word is shown directly; masked to zero while empty so stale storage never leaks out.
        assign rd_valid = ~empty;
        assign rd_data  = empty ? '0 : mem_rdata;
    end else begin : g_reg_rd
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem_rdata;
                end
            end
        end

        assign rd_valid = rd_valid_q;
        assign rd_data  = rd_data_q;
    end

endmodule
`default_nettype wire
